cmd_engine: RTL and testbench
=============================

Name: cmd_engine

Overview:
Next-generation SPI command decoder for the snake VGA display. It buffers complete SPI command packets in a small FIFO and decodes them into score updates and framebuffer writes. It adds multi-cell commands (horizontal run, full-screen clear) that a write sequencer executes with a ready/valid handshake toward the framebuffer. It sits between the SPI receiver and the framebuffer/score display. Grid size, colour width, score width and FIFO depth are parametrised.

Parameters:
X_BITS, 5, column address bits (grid width 2^X_BITS)
Y_BITS, 5, row address bits (grid height 2^Y_BITS)
COLOR_W, 3, colour code width (1..5)
SCORE_W, 10, score register width (1..16)
DEPTH, 4, packet FIFO depth (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
spi_done  in  1  one-cycle pulse: packet bytes valid this cycle
command  in  8  packet byte 0 (opcode/colour)
databyte1  in  8  packet byte 1
databyte2  in  8  packet byte 2
wready  in  1  framebuffer accepts write this cycle
we  out  1  write valid
waddr  out  X_BITS+Y_BITS  write address {y, x}
wdata  out  COLOR_W  write colour
score  out  SCORE_W  current score
cmd_ack  out  1  one-cycle pulse: packet accepted into FIFO
busy  out  1  FIFO non-empty or sequencer not IDLE
overflow  out  1  sticky: packet dropped on full FIFO
err_count  out  8  saturating count of unknown opcodes

Behaviour:
- Reset asserted (reset=0): all outputs 0, FIFO emptied, FSM to IDLE, in-flight run abandoned; takes effect immediately, async.
- Opcode = command[7:5]; colour c = command[COLOR_W-1:0].
  - 000 NOP: popped, no effect.
  - 001 CELL: one write, y = databyte1[Y_BITS-1:0], x = databyte2[X_BITS-1:0].
  - 010 SCORE: score <= {databyte1,databyte2}[SCORE_W-1:0]; no write.
  - 011 HRUN: writes c to row y, x from databyte2 start through 2^X_BITS-1, ascending x.
  - 100 CLEAR: writes c to every address 0..2^(X_BITS+Y_BITS)-1, ascending.
  - 101-111: err_count += 1, saturating at 255; no other effect.
- FIFO push: on a clk edge where spi_done=1, the packet is stored if the pre-edge count < DEPTH, and cmd_ack=1 for the following cycle. Otherwise the packet is dropped, overflow is set to 1 (cleared only by reset) and cmd_ack stays 0. A simultaneous pop does not rescue a push to a full FIFO.
- FSM states: IDLE, DECODE, WRITE.
  - IDLE: when the FIFO is non-empty, pop the head into the decode register -> DECODE.
  - DECODE: NOP/SCORE/unknown take effect at this edge -> IDLE. CELL/HRUN/CLEAR load the address counter -> WRITE.
  - WRITE: we=1, with waddr/wdata stable until the edge where wready=1.
    - On accept, the last address (CELL; x wrap for HRUN; full-count wrap for CLEAR) -> IDLE.
    - Otherwise the address increments and we stays 1 the next cycle.
- Latency with the FIFO empty and FSM IDLE:
  - spi_done in cycle 0 -> packet in FIFO at the edge ending cycle 0 -> popped at the edge ending cycle 1.
  - CELL/HRUN/CLEAR: we=1 from cycle 3.
  - SCORE: new score visible in cycle 3.
- Throughput: one write per cycle while wready=1.
  - Back-to-back packets: 2 idle cycles between executions (IDLE and DECODE).
- Address counter width X_BITS+Y_BITS; HRUN increments only x, and y is held.
- An HRUN with start x = 2^X_BITS-1 performs exactly 1 write.
- busy = (count != 0) | (state != IDLE).
- wready while we=0 is ignored.

Test Plan:
- Reset, then CELL (command=0x25, b1=0x03, b2=0x07), wready=1 -> we=1 in cycle 3 only, waddr={5'd3,5'd7}=0x067, wdata=5, cmd_ack pulse in cycle 1.
- SCORE (command=0x40, b1=0x02, b2=0x9A) -> score=0x29A from cycle 3, we never asserts.
- HRUN (command=0x62, b1=0x01, b2=0x1C) with wready toggling 1,0,1,1,0,1 -> exactly 4 accepted writes, addresses 0x03C..0x03F, colour 2; addr/data stable while wready=0; busy falls after the last accept.
- CLEAR colour 7, wready=1 -> exactly 1024 consecutive writes 0x000..0x3FF, then IDLE.
- While CLEAR is in progress, push 5 CELL packets (DEPTH=4) -> 4 cmd_acks, overflow=1 after the 5th; the 4 queued CELLs execute in order after CLEAR.
- 256 unknown opcodes 0xE0 -> err_count=255 (saturated). Separately, assert reset mid-HRUN -> we=0 and FIFO empty immediately; no further writes after reset is released.

Source files
------------

// File: rtl/cmd_engine.sv
// rtl/cmd_engine.sv - SPI packet FIFO and command decoder with multi-cell write sequencer
module cmd_engine #(
    parameter int X_BITS  = 5,
    parameter int Y_BITS  = 5,
    parameter int COLOR_W = 3,
    parameter int SCORE_W = 10,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       spi_done,
    input  logic [7:0]                 command,
    input  logic [7:0]                 databyte1,
    input  logic [7:0]                 databyte2,
    input  logic                       wready,
    output logic                       we,
    output logic [X_BITS+Y_BITS-1:0]   waddr,
    output logic [COLOR_W-1:0]         wdata,
    output logic [SCORE_W-1:0]         score,
    output logic                       cmd_ack,
    output logic                       busy,
    output logic                       overflow,
    output logic [7:0]                 err_count
);

    localparam int AW = X_BITS + Y_BITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [PW-1:0]     PTR_ONE = PW'(1);
    localparam logic [AW-1:0]     ADR_ONE = AW'(1);
    localparam logic [X_BITS-1:0] X_ONE   = X_BITS'(1);

    localparam logic [2:0] OP_CELL  = 3'b001;
    localparam logic [2:0] OP_SCORE = 3'b010;
    localparam logic [2:0] OP_HRUN  = 3'b011;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t        state;
    logic [23:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [23:0]   dec;
    logic [2:0]    dec_op;
    logic          push;
    logic          pop;
    logic          last_addr;
    logic          unused_bits;

    // Push is judged on the pre-edge count only, so a same-cycle pop never frees a slot for it
    assign push   = spi_done && (count < DEPTH_C);
    assign pop    = (state == IDLE) && (count != '0);
    assign busy   = (count != '0) || (state != IDLE);
    assign dec_op = dec[23:21];
    assign unused_bits = ^dec;

    // Final address of the running command: CELL is single, HRUN ends at x wrap, CLEAR at full wrap
    always_comb begin
        last_addr = 1'b1;
        case (dec_op)
            OP_HRUN:  last_addr = &waddr[X_BITS-1:0];
            OP_CLEAR: last_addr = &waddr;
            default:  last_addr = 1'b1;
        endcase
    end

    // FIFO pointers, occupancy, acknowledge pulse and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmd_ack  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cmd_ack <= push;
            if (spi_done && !push) overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Packet storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {command, databyte1, databyte2};
    end

    // Command FSM: pop, decode, then sequence framebuffer writes under the wready handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dec       <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            score     <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        dec   <= mem[rd_ptr];
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state <= IDLE;
                    case (dec_op)
                        OP_CELL, OP_HRUN: begin
                            waddr <= {dec[8 +: Y_BITS], dec[0 +: X_BITS]};
                            wdata <= dec[16 +: COLOR_W];
                            we    <= 1'b1;
                            state <= WRITE;
                        end
                        OP_CLEAR: begin
                            waddr <= '0;
                            wdata <= dec[16 +: COLOR_W];
                            we    <= 1'b1;
                            state <= WRITE;
                        end
                        OP_SCORE: score <= dec[SCORE_W-1:0];
                        3'b101, 3'b110, 3'b111: begin
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                        default: ;
                    endcase
                end
                WRITE: begin
                    if (wready) begin
                        if (last_addr) begin
                            we    <= 1'b0;
                            state <= IDLE;
                        end else if (dec_op == OP_HRUN) begin
                            waddr <= {waddr[AW-1:X_BITS], waddr[X_BITS-1:0] + X_ONE};
                        end else begin
                            waddr <= waddr + ADR_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_engine.sv
// tb/tb_cmd_engine.sv - randomized self-checking bench for cmd_engine against a behavioural model
module tb_cmd_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_done = 1'b0;
    logic [7:0] command = '0;
    logic [7:0] databyte1 = '0;
    logic [7:0] databyte2 = '0;
    logic       wready = 1'b0;
    logic       we;
    logic [9:0] waddr;
    logic [2:0] wdata;
    logic [9:0] score;
    logic       cmd_ack;
    logic       busy;
    logic       overflow;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sent_cyc = 0;

    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int ack_cyc[$];
    int we_cyc[$];
    int stall_viol = 0;
    bit held = 0;
    logic [9:0] held_addr;
    logic [2:0] held_data;

    int exp_addr[$];
    int exp_data[$];
    int exp_score = 0;
    int exp_err = 0;

    cmd_engine dut (
        .clk(clk), .reset(reset), .spi_done(spi_done), .command(command),
        .databyte1(databyte1), .databyte2(databyte2), .wready(wready),
        .we(we), .waddr(waddr), .wdata(wdata), .score(score), .cmd_ack(cmd_ack),
        .busy(busy), .overflow(overflow), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe accepted writes, acks, we cycles and hold violations away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            if (we && wready) begin
                obs_addr.push_back(int'(waddr));
                obs_data.push_back(int'(wdata));
                obs_cyc.push_back(cyc);
            end
            if (we) we_cyc.push_back(cyc);
            if (cmd_ack) ack_cyc.push_back(cyc);
            if (held && (!we || waddr !== held_addr || wdata !== held_data)) stall_viol++;
            held = we && !wready;
            held_addr = waddr;
            held_data = wdata;
        end else begin
            held = 0;
        end
    end

    // Behavioural model: what a packet must produce on the framebuffer and registers
    task automatic model_packet(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        int op, col, y, x;
        op  = int'(c) / 32;
        col = int'(c) % 8;
        y   = int'(b1) % 32;
        x   = int'(b2) % 32;
        case (op)
            1: begin exp_addr.push_back(y * 32 + x); exp_data.push_back(col); end
            2: exp_score = (int'(b1) * 256 + int'(b2)) % 1024;
            3: for (int i = x; i < 32; i++) begin exp_addr.push_back(y * 32 + i); exp_data.push_back(col); end
            4: for (int i = 0; i < 1024; i++) begin exp_addr.push_back(i); exp_data.push_back(col); end
            5, 6, 7: if (exp_err < 255) exp_err++;
            default: ;
        endcase
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        ack_cyc.delete(); we_cyc.delete();
        exp_addr.delete(); exp_data.delete();
        stall_viol = 0;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        @(posedge clk); #1;
        spi_done = 1'b1; command = c; databyte1 = b1; databyte2 = b2;
        sent_cyc = cyc;
        @(posedge clk); #1;
        spi_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc, output bit ok);
        ok = 0;
        idle_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin idle_cyc = cyc; ok = 1; return; end
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({we, cmd_ack, busy, overflow} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {we, cmd_ack, busy, overflow}); end
        checks++; if (waddr !== 10'd0 || wdata !== 3'd0) begin errors++; $display("FAIL reset_wr: got %h/%h want 0/0", waddr, wdata); end
        checks++; if (score !== 10'd0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_regs: got %h/%h want 0/0", score, err_count); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL reset_release: busy=%b we=%b want 0/0", busy, we); end
    endtask

    task automatic test_cell();
        int ic; bit ok; int d; logic [7:0] b1, b2, c;
        clear_obs();
        wready = 1'b1;
        send(8'h25, 8'h03, 8'h07);
        model_packet(8'h25, 8'h03, 8'h07);
        wait_idle(50, ic, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cell_timeout: busy stuck, want idle within 50"); end
        checks++; if (ack_cyc.size() != 1 || ack_cyc[0] != sent_cyc + 1) begin errors++; $display("FAIL cell_ack: got %0d acks first@%0d want 1 @%0d", ack_cyc.size(), ack_cyc.size() ? ack_cyc[0] : -1, sent_cyc + 1); end
        checks++; if (we_cyc.size() != 1 || we_cyc[0] != sent_cyc + 3) begin errors++; $display("FAIL cell_we_cycle: got %0d cycles first@%0d want 1 @%0d", we_cyc.size(), we_cyc.size() ? we_cyc[0] : -1, sent_cyc + 3); end
        checks++; if (obs_addr.size() != 1 || obs_addr[0] != 'h067 || obs_data[0] != 5) begin errors++; $display("FAIL cell_write: got %0d writes addr %h data %0d want 1 067 5", obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1, obs_data.size() ? obs_data[0] : -1); end
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            c = 8'h20 | 8'($urandom_range(0, 31)); b1 = 8'($urandom); b2 = 8'($urandom);
            send(c, b1, b2);
            model_packet(c, b1, b2);
            wait_idle(50, ic, ok);
        end
        checks++; if (obs_addr.size() != exp_addr.size()) begin errors++; $display("FAIL cell_rand_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL cell_rand_seq: idx %0d got %h/%0d want %h/%0d", d, obs_addr[d], obs_data[d], exp_addr[d], exp_data[d]); end
    endtask

    task automatic test_score();
        int ic; bit ok; logic [9:0] old; logic [7:0] b1, b2;
        clear_obs();
        old = 10'(exp_score);
        send(8'h40, 8'h02, 8'h9A);
        model_packet(8'h40, 8'h02, 8'h9A);
        @(negedge clk);
        @(negedge clk);
        checks++; if (score !== old) begin errors++; $display("FAIL score_early: got %h want %h at cycle 2", score, old); end
        @(negedge clk);
        checks++; if (score !== 10'h29A || int'(score) != exp_score) begin errors++; $display("FAIL score_value: got %h want 29a", score); end
        for (int i = 0; i < 4; i++) begin
            b1 = 8'($urandom); b2 = 8'($urandom);
            send(8'h40 | 8'($urandom_range(0, 31)), b1, b2);
            model_packet(8'h40, b1, b2);
            wait_idle(50, ic, ok);
            checks++; if (int'(score) != exp_score) begin errors++; $display("FAIL score_rand: got %h want %h", score, exp_score); end
        end
        checks++; if (we_cyc.size() != 0) begin errors++; $display("FAIL score_no_write: got %0d we cycles want 0", we_cyc.size()); end
    endtask

    task automatic test_hrun();
        int ic; bit ok; int d; logic [5:0] pat; logic [7:0] b1, b2, c;
        pat = 6'b101101;
        clear_obs();
        wready = pat[0];
        send(8'h62, 8'h01, 8'h1C);
        model_packet(8'h62, 8'h01, 8'h1C);
        ic = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            wready = pat[i % 6];
            @(negedge clk);
            if (!busy) begin ic = cyc; break; end
        end
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL hrun_count: got %0d want 4", obs_addr.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL hrun_seq: idx %0d got %h/%0d want %h/%0d", d, obs_addr[d], obs_data[d], exp_addr[d], exp_data[d]); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL hrun_stable: got %0d hold violations want 0", stall_viol); end
        checks++; if (obs_cyc.size() == 0 || ic != obs_cyc[$] + 1) begin errors++; $display("FAIL hrun_busy_fall: idle@%0d want %0d", ic, obs_cyc.size() ? obs_cyc[$] + 1 : -1); end
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            c = 8'h60 | 8'($urandom_range(0, 7)); b1 = 8'($urandom);
            b2 = (i == 0) ? 8'h1F : 8'($urandom);
            send(c, b1, b2);
            model_packet(c, b1, b2);
            for (int k = 0; k < 300; k++) begin
                @(posedge clk); #1;
                wready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (!busy) break;
            end
            if (i == 0) begin
                checks++; if (obs_addr.size() != 1) begin errors++; $display("FAIL hrun_edge_x31: got %0d writes want 1", obs_addr.size()); end
            end
        end
        checks++; if (obs_addr.size() != exp_addr.size()) begin errors++; $display("FAIL hrun_rand_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL hrun_rand_seq: idx %0d got %h/%0d want %h/%0d", d, obs_addr[d], obs_data[d], exp_addr[d], exp_data[d]); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL hrun_rand_stable: got %0d hold violations want 0", stall_viol); end
    endtask

    task automatic test_back_to_back();
        int ic; bit ok; int d; int gap_bad; logic [7:0] b1, b2, c;
        clear_obs();
        wready = 1'b1;
        send(8'h87, 8'h00, 8'h00);
        model_packet(8'h87, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        ack_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            c = 8'h20 | 8'($urandom_range(0, 7)); b1 = 8'($urandom); b2 = 8'($urandom);
            send(c, b1, b2);
            if (i < 4) model_packet(c, b1, b2);
            if (i == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0 after 4 pushes", overflow); end
            end
        end
        @(negedge clk);
        checks++; if (ack_cyc.size() != 4) begin errors++; $display("FAIL ovf_acks: got %0d want 4", ack_cyc.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        wait_idle(3000, ic, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_timeout: busy stuck, want idle within 3000"); end
        checks++; if (obs_addr.size() != 1028) begin errors++; $display("FAIL clear_count: got %0d want 1028", obs_addr.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL clear_seq: idx %0d got %h/%0d want %h/%0d", d, obs_addr[d], obs_data[d], exp_addr[d], exp_data[d]); end
        gap_bad = 0;
        if (obs_cyc.size() == 1028) begin
            if (obs_cyc[1023] - obs_cyc[0] != 1023) gap_bad++;
            for (int i = 1024; i < 1028; i++) if (obs_cyc[i] - obs_cyc[i-1] != 3) gap_bad++;
        end else gap_bad = 1;
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_timing: got %0d bad gaps want 0", gap_bad); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_errors();
        int ic; bit ok; int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'hE0, 8'($urandom), 8'($urandom));
            model_packet(8'hE0, 8'h00, 8'h00);
            wait_idle(50, ic, ok);
            if (!ok) bad++;
            if (i == 99) begin
                checks++; if (int'(err_count) != exp_err) begin errors++; $display("FAIL err_mid: got %0d want %0d", err_count, exp_err); end
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL err_timeout: got %0d stuck packets want 0", bad); end
        checks++; if (err_count !== 8'd255 || exp_err != 255) begin errors++; $display("FAIL err_saturate: got %0d want 255", err_count); end
    endtask

    task automatic test_reset_mid_hrun();
        int seen;
        clear_obs();
        wready = 1'b1;
        send(8'h61, 8'($urandom), 8'h00);
        send(8'h25, 8'h01, 8'h01);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (we) seen = 1; end
        checks++; if (!seen) begin errors++; $display("FAIL rst_hrun_start: we never rose, want 1"); end
        @(negedge clk);
        #2 reset = 1'b0;
        exp_score = 0; exp_err = 0;
        #1;
        checks++; if (we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: we=%b busy=%b want 0/0", we, busy); end
        checks++; if (int'(score) != exp_score || int'(err_count) != exp_err || overflow !== 1'b0) begin errors++; $display("FAIL rst_regs: score=%h err=%0d ovf=%b want 0", score, err_count, overflow); end
        clear_obs();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++; if (obs_addr.size() != 0 || we_cyc.size() != 0) begin errors++; $display("FAIL rst_no_writes: got %0d writes want 0", obs_addr.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_cell();
        test_score();
        test_hrun();
        test_back_to_back();
        test_errors();
        test_reset_mid_hrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
